// File: rtl/maltsev_op_pkg.sv
// maltsev_op_pkg -- definitions shared by the Maltsev operation blocks.
//
// Contents:
//   op_state_t / ST_IDLE / ST_BUSY : operation FSM encoding (IDLE=0, BUSY=1)
//   RD_IDLE / RD_BUSY              : levels of the RD handshake output
//   clog2()                        : constant-evaluable ceiling log2 used to
//                                    size selector and counter fields
package maltsev_op_pkg;

   typedef logic [0:0] op_state_t;

   localparam op_state_t ST_IDLE = 1'b0;
   localparam op_state_t ST_BUSY = 1'b1;

   localparam logic RD_IDLE = 1'b1;
   localparam logic RD_BUSY = 1'b0;

   // Smallest r with 2**r >= n; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/st_edge_det.sv
// st_edge_det -- start-request detector shared by the Maltsev operation blocks.
//
// Ports:
//   CLK  in  clock, rising edge active
//   RST  in  asynchronous active-low reset
//   ST   in  start level from the requester
//   REQ  out 1 while ST=1 and the previous sampled ST was 0; the owning
//            block treats REQ at a rising CLK edge as one start request
module st_edge_det
   import maltsev_op_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic ST,
   output logic REQ
);

   logic st_old_d;
   logic st_old_q;

   // Next value of the previous-ST sample.
   always_comb begin
      st_old_d = ST;
   end

   // Previous-ST register; cleared on reset so ST already high at release is a request.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         st_old_q <= 1'b0;
      end else begin
         st_old_q <= st_old_d;
      end
   end

   // Kept combinational so the owning block acts on the very edge that sees the 0->1 step.
   assign REQ = ST & ~st_old_q;

endmodule

// File: rtl/operation_proj_n.sv
// operation_proj_n -- projection operator of the Maltsev operation library.
// On a start request it captures operand channel SEL of IN into RES and
// raises RD LAT cycles after the accepting edge.
//
// Parameters: BW (word width), NIN (channel count, >=2), LAT (latency, >=1),
//             SW (SEL width, derived from NIN).
// Ports:
//   CLK   in   clock, rising edge active
//   RST   in   asynchronous active-low reset
//   ST    in   start level; 0->1 step sampled on CLK requests an operation
//   SEL   in   SW      operand index, sampled on the accepting edge
//   IN    in   NIN*BW  flattened operands, channel k = IN[k*BW +: BW]
//   RES   out  BW      result register
//   RD    out  1 = idle and RES valid
//   ERR   out  last accepted operation had SEL >= NIN
//   OVR   out  sticky: a start request arrived while busy
//   OPCNT out  16-bit accepted-operation counter, present only when the
//              macro OPERATION_PROJ_N_CNT_EN is defined
module operation_proj_n
   import maltsev_op_pkg::*;
#(
   parameter int BW  = 16,
   parameter int NIN = 2,
   parameter int LAT = 1,
   parameter int SW  = clog2(NIN)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ST,
   input  logic [SW-1:0]     SEL,
   input  logic [NIN*BW-1:0] IN,
   output logic [BW-1:0]     RES,
   output logic              RD,
   output logic              ERR,
   output logic              OVR
`ifdef OPERATION_PROJ_N_CNT_EN
   ,
   output logic [15:0]       OPCNT
`endif
);

   // Counter holds at most LAT-1; keep at least one bit for LAT=1.
   localparam int CW = (LAT > 1) ? clog2(LAT) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

   logic            req_s;
   logic            sel_ok_s;
   logic [BW-1:0]   mux_s;

   op_state_t       state_d, state_q;
   logic [CW-1:0]   cnt_d,   cnt_q;
   logic [BW-1:0]   res_d,   res_q;
   logic            rd_d,    rd_q;
   logic            err_d,   err_q;
   logic            ovr_d,   ovr_q;

   st_edge_det u_st_edge_det (
      .CLK (CLK),
      .RST (RST),
      .ST  (ST),
      .REQ (req_s)
   );

   // Codes NIN..2**SW-1 are invalid; there is no wrap-around onto real channels.
   assign sel_ok_s = (32'(SEL) < 32'(NIN));

   // Channel mux; evaluates to zero for an invalid index.
   always_comb begin
      mux_s = '0;
      for (int k = 0; k < NIN; k++) begin
         mux_s = (32'(SEL) == 32'(k)) ? IN[k*BW +: BW] : mux_s;
      end
   end

   // Operation FSM: capture on an idle request, then count down the latency.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      rd_d    = rd_q;
      err_d   = err_q;
      ovr_d   = ovr_q;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               res_d   = mux_s;
               err_d   = ~sel_ok_s;
               rd_d    = RD_BUSY;
               cnt_d   = CNT_INIT;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // A request here is dropped, including one on the edge that ends the operation.
            if (req_s) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            if (cnt_q == '0) begin
               rd_d    = RD_IDLE;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            rd_d    = RD_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         rd_q    <= RD_IDLE;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   assign RES = res_q;
   assign RD  = rd_q;
   assign ERR = err_q;
   assign OVR = ovr_q;

`ifdef OPERATION_PROJ_N_CNT_EN
   logic        accept_s;
   logic [15:0] opcnt_d, opcnt_q;

   assign accept_s = req_s & (state_q == ST_IDLE);

   // Accepted-operation count; wraps naturally at 16 bits.
   always_comb begin
      if (accept_s) begin
         opcnt_d = opcnt_q + 16'd1;
      end else begin
         opcnt_d = opcnt_q;
      end
   end

   // Operation counter register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         opcnt_q <= 16'd0;
      end else begin
         opcnt_q <= opcnt_d;
      end
   end

   assign OPCNT = opcnt_q;
`endif

endmodule

// File: tb/tb_operation_proj_n.sv
// tb_operation_proj_n -- scoreboard bench for operation_proj_n.
// Three instances: u_a (NIN=4, LAT=1), u_b (NIN=4, LAT=5), u_c (NIN=3, LAT=4).
// Stimulus pushes {instance, RES, ERR, latency} per accepted operation; a
// monitor pops one entry on every RD rising edge and compares.
// Build with +define+OPERATION_PROJ_N_CNT_EN to exercise OPCNT as well.
`timescale 1ns/1ps
module tb_operation_proj_n;

   localparam int NG = 3;
   localparam int LAT_T [NG] = '{1, 5, 4};

   typedef struct {
      int          g;
      logic [15:0] res;
      logic        err;
      int          lat;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [NG-1:0]   st;
   logic [1:0]      sel [NG];
   logic [63:0]     in_a;
   logic [63:0]     in_b;
   logic [47:0]     in_c;
   logic [15:0]     res [NG];
   logic [NG-1:0]   rd;
   logic [NG-1:0]   err;
   logic [NG-1:0]   ovr;
`ifdef OPERATION_PROJ_N_CNT_EN
   logic [15:0]     opcnt [NG];
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q [$];
   int   low_cnt [NG];
   logic [NG-1:0] rd_prev;

   operation_proj_n #(.BW(16), .NIN(4), .LAT(1)) u_a (
      .CLK(clk), .RST(rst_n), .ST(st[0]), .SEL(sel[0]), .IN(in_a),
      .RES(res[0]), .RD(rd[0]), .ERR(err[0]), .OVR(ovr[0])
`ifdef OPERATION_PROJ_N_CNT_EN
      , .OPCNT(opcnt[0])
`endif
   );

   operation_proj_n #(.BW(16), .NIN(4), .LAT(5)) u_b (
      .CLK(clk), .RST(rst_n), .ST(st[1]), .SEL(sel[1]), .IN(in_b),
      .RES(res[1]), .RD(rd[1]), .ERR(err[1]), .OVR(ovr[1])
`ifdef OPERATION_PROJ_N_CNT_EN
      , .OPCNT(opcnt[1])
`endif
   );

   operation_proj_n #(.BW(16), .NIN(3), .LAT(4)) u_c (
      .CLK(clk), .RST(rst_n), .ST(st[2]), .SEL(sel[2]), .IN(in_c),
      .RES(res[2]), .RD(rd[2]), .ERR(err[2]), .OVR(ovr[2])
`ifdef OPERATION_PROJ_N_CNT_EN
      , .OPCNT(opcnt[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_op(input int g, input logic [15:0] r, input logic e);
      exp_t x;
      x.g   = g;
      x.res = r;
      x.err = e;
      x.lat = LAT_T[g];
      exp_q.push_back(x);
   endtask

   task automatic start(input int g, input logic [1:0] s);
      sel[g] = s;
      st[g]  = 1'b1;
      tick();
      st[g]  = 1'b0;
   endtask

   task automatic wait_done(input int g);
      int n;
      n = 0;
      while (rd[g] !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk($sformatf("rd_timeout_%0d", g), {31'd0, rd[g]}, 32'd1);
      tick();
   endtask

   // Monitor: pop and compare one expected entry on each RD rising edge.
   initial begin
      exp_t e;
      for (int g = 0; g < NG; g++) low_cnt[g] = 0;
      rd_prev = '1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            for (int g = 0; g < NG; g++) low_cnt[g] = 0;
            rd_prev = '1;
         end else begin
            for (int g = 0; g < NG; g++) begin
               if (rd[g] !== 1'b1) begin
                  low_cnt[g]++;
               end else if (rd_prev[g] !== 1'b1) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_rd inst=%0d actual=rise required=none", g);
                  end else begin
                     e = exp_q.pop_front();
                     chk("sb_inst", 32'(g), 32'(e.g));
                     chk($sformatf("sb_res_%0d", g), {16'd0, res[g]}, {16'd0, e.res});
                     chk($sformatf("sb_err_%0d", g), {31'd0, err[g]}, {31'd0, e.err});
                     chk($sformatf("sb_lat_%0d", g), 32'(low_cnt[g]), 32'(e.lat));
                  end
                  low_cnt[g] = 0;
               end
               rd_prev[g] = rd[g];
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b1;
      st    = '0;
      for (int g = 0; g < NG; g++) sel[g] = 2'd0;
      in_a  = 64'hDDDD_CCCC_BBBB_AAAA;
      in_b  = 64'hDDDD_CCCC_BBBB_AAAA;
      in_c  = 48'hCCCC_BBBB_AAAA;
      #2;
      rst_n = 1'b0;
      st[0]  = 1'b1;
      sel[0] = 2'd2;
      #1;
      for (int g = 0; g < NG; g++) begin
         chk($sformatf("rst_rd_%0d", g),  {31'd0, rd[g]},  32'd1);
         chk($sformatf("rst_res_%0d", g), {16'd0, res[g]}, 32'd0);
         chk($sformatf("rst_err_%0d", g), {31'd0, err[g]}, 32'd0);
         chk($sformatf("rst_ovr_%0d", g), {31'd0, ovr[g]}, 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // ST already high at release: first edge is a request.
      expect_op(0, 16'hCCCC, 1'b0);
      tick();
      st[0] = 1'b0;
      wait_done(0);
      chk("a_err", {31'd0, err[0]}, 32'd0);

      expect_op(0, 16'hDDDD, 1'b0);
      start(0, 2'd3);
      wait_done(0);
      expect_op(0, 16'hAAAA, 1'b0);
      start(0, 2'd0);
      wait_done(0);

      // Latency 5; IN and SEL changes while busy must not reach RES.
      expect_op(1, 16'hAAAA, 1'b0);
      start(1, 2'd0);
      tick();
      in_b   = 64'h1111_2222_3333_4444;
      sel[1] = 2'd3;
      wait_done(1);
      chk("b_res_hold", {16'd0, res[1]}, 32'h0000_AAAA);
      in_b = 64'hDDDD_CCCC_BBBB_AAAA;

      // ST held high for 10 cycles: one operation only.
      expect_op(1, 16'hBBBB, 1'b0);
      sel[1] = 2'd1;
      st[1]  = 1'b1;
      repeat (10) tick();
      st[1] = 1'b0;
      repeat (3) tick();
      chk("b_held_ovr", {31'd0, ovr[1]}, 32'd0);

      // Request on the edge that returns RD high is ignored and sets OVR.
      expect_op(1, 16'hCCCC, 1'b0);
      start(1, 2'd2);
      repeat (4) tick();
      sel[1] = 2'd0;
      st[1]  = 1'b1;
      tick();
      chk("b2b_rd", {31'd0, rd[1]}, 32'd1);
      chk("b2b_ovr", {31'd0, ovr[1]}, 32'd1);
      st[1] = 1'b0;
      repeat (3) tick();
      chk("b2b_res", {16'd0, res[1]}, 32'h0000_CCCC);

      // Invalid index on the 3-channel instance, then a valid one.
      expect_op(2, 16'h0000, 1'b1);
      start(2, 2'd3);
      wait_done(2);
      chk("c_err_set", {31'd0, err[2]}, 32'd1);
      expect_op(2, 16'hBBBB, 1'b0);
      start(2, 2'd1);
      wait_done(2);
      chk("c_err_clr", {31'd0, err[2]}, 32'd0);

      // Overrun two cycles after the accepting edge.
      expect_op(2, 16'hCCCC, 1'b0);
      start(2, 2'd2);
      tick();
      sel[2] = 2'd0;
      in_c   = 48'h1234_5678_9ABC;
      st[2]  = 1'b1;
      tick();
      st[2] = 1'b0;
      chk("ovr_busy_rd", {31'd0, rd[2]}, 32'd0);
      chk("ovr_set", {31'd0, ovr[2]}, 32'd1);
      wait_done(2);
      chk("ovr_res", {16'd0, res[2]}, 32'h0000_CCCC);
      in_c = 48'hCCCC_BBBB_AAAA;
      expect_op(2, 16'hAAAA, 1'b0);
      start(2, 2'd0);
      wait_done(2);
      chk("ovr_sticky", {31'd0, ovr[2]}, 32'd1);

      // Reset in the middle of an operation aborts it.
      expect_op(1, 16'hDDDD, 1'b0);
      start(1, 2'd3);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_rd", {31'd0, rd[1]}, 32'd1);
      chk("abort_res", {16'd0, res[1]}, 32'd0);
      chk("abort_ovr", {31'd0, ovr[1]}, 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (10) tick();
      chk("abort_no_rd", {31'd0, rd[1]}, 32'd1);

`ifdef OPERATION_PROJ_N_CNT_EN
      // Three accepted operations plus one overrun.
      expect_op(2, 16'hAAAA, 1'b0);
      start(2, 2'd0);
      wait_done(2);
      expect_op(2, 16'hBBBB, 1'b0);
      start(2, 2'd1);
      wait_done(2);
      expect_op(2, 16'hCCCC, 1'b0);
      start(2, 2'd2);
      tick();
      st[2] = 1'b1;
      tick();
      st[2] = 1'b0;
      wait_done(2);
      chk("opcnt_3", {16'd0, opcnt[2]}, 32'd3);
      force u_c.opcnt_q = 16'hFFFF;
      #1;
      release u_c.opcnt_q;
      expect_op(2, 16'hAAAA, 1'b0);
      start(2, 2'd0);
      wait_done(2);
      chk("opcnt_wrap", {16'd0, opcnt[2]}, 32'd0);
`endif

      repeat (2) tick();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operation_proj_n.md
Name: operation_proj_n

Overview:
- Parametrised projection operator for the Maltsev operation library: on a start request, captures one of NIN operand words of width BW, selected at run time by SEL, into RES.
- Raises RD after a programmable number of cycles, so pipelines built from operation blocks see realistic, configurable operator latency.
- Shares the ST/RD handshake used by the other operation blocks: a rising edge on ST starts an operation, RD=1 means RES is valid and the block is idle.

Parameters:
- BW, 16, operand and result width in bits (>=1).
- NIN, 2, number of operand channels (>=2).
- LAT, 1, cycles from the accepting edge to RD rising (>=1).
- SW, $clog2(NIN), width of SEL (derived; do not override).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-low; RST=0 forces the reset state immediately.
- ST  in  1  start level; a 0->1 transition sampled on CLK is a start request.
- SEL  in  SW  operand index, sampled on the accepting edge.
- IN  in  NIN*BW  flattened operands; channel k = IN[k*BW +: BW].
- RES  out  BW  result register.
- RD  out  1  ready/done; 1 = idle and RES valid.
- ERR  out  1  last accepted operation had SEL>=NIN.
- OVR  out  1  sticky: a start request arrived while BUSY.

Behaviour:
- Reset values (RST=0, asynchronous): RD=1, RES=0, ERR=0, OVR=0, STold=0, state=IDLE, cnt=0.
- Start detect: STold <= ST every cycle. A request is ST=1 && STold=0 at a clock edge.
- States are IDLE and BUSY.
- IDLE + request at edge N:
  - RES <= IN[SEL] if SEL<NIN; otherwise RES <= 0 and ERR <= 1.
  - ERR <= 0 when SEL is valid.
  - RD <= 0, cnt <= LAT-1, state <= BUSY.
- BUSY:
  - If cnt==0: RD <= 1, state <= IDLE.
  - Otherwise cnt decrements.
  - RD therefore rises at edge N+LAT, and is low for exactly LAT cycles.
- RES is held constant from edge N until the next accepted request. Changes on IN or SEL while BUSY have no effect.
- Request while BUSY:
  - Ignored: no recapture, no timer restart.
  - OVR <= 1; OVR stays set until reset.
- Back-to-back operation:
  - A request on the same edge that returns RD to 1 is still a BUSY-state request: it is ignored and sets OVR.
  - ST held high generates only one request. ST must return low for at least one sampled cycle before the next request.
- ST high at reset release: STold=0 after reset, so the first edge with ST=1 is a request.
- Reset during BUSY: the operation is aborted, all outputs take their reset values, and no RD pulse occurs.
- Non-power-of-two NIN: SEL codes NIN..2^SW-1 are the invalid-index case; there is no wrap-around.

Optional Feature:
- Macro OPERATION_PROJ_N_CNT_EN.
- When defined:
  - Adds output port OPCNT, 16 bits, reset 0.
  - OPCNT increments on every accepted request, wraps 0xFFFF->0x0000, and is not incremented by ignored (OVR) requests.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package maltsev_op_pkg:
  - State encoding (IDLE=0, BUSY=1).
  - Clog2 helper function.
  - Shared handshake constants: RD_IDLE=1, RD_BUSY=0.
- Sub-module st_edge_det (CLK, RST, ST -> REQ): holds STold and produces the 1-cycle request. It is reused by the other operation blocks.
- Channel mux and latency counter stay inline.

Test Plan:
- Reset/basic: BW=16, NIN=4, LAT=1; RST low then high; IN={0xDDDD,0xCCCC,0xBBBB,0xAAAA} (ch3..ch0); SEL=2; ST pulse -> RD low 1 cycle, RES=0xCCCC, ERR=0.
- Latency: LAT=5, SEL=0 -> RD low exactly 5 cycles after the accepting edge, RES=0xAAAA; change IN during BUSY -> RES unchanged.
- Invalid index: NIN=3, SEL=3 -> RES=0, ERR=1; next request with SEL=1 -> ERR=0, RES=ch1.
- Overrun: LAT=4; second ST rising edge 2 cycles after the first -> RD still rises at N+4, RES from the first request, OVR=1 and stays set.
- Held ST and abort: ST held high 10 cycles -> exactly one operation; separately, RST=0 mid-BUSY -> RD=1, RES=0 asynchronously, no later RD edge.
- CNT_EN build: 3 accepted requests plus 1 overrun -> OPCNT=3; preload to 0xFFFF via forced stimulus, one more request -> OPCNT=0.
